// File: rtl/replay_timer.sv
// Link-layer replay timer: sequence assignment, ACK/NAK window checking,
// timeout detection and replay-count tracking for a replay buffer.
module replay_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [1:0]  ack_nack,
  input  logic [11:0] ack_seq,
  input  logic        replay_done,
  output logic [11:0] next_seq,
  output logic        tim_out,
  output logic        replay_active,
  output logic [1:0]  replay_num,
  output logic        rollover,
  output logic        ack_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    REPLAY = 2'b10
  } state_t;

  localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [11:0] last_tx, last_tx_d;
  logic [11:0] acked_seq, acked_seq_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  replay_num_d, rn_base;
  logic        tim_out_d, rollover_d, ack_err_d;

  logic        is_ack, is_nak, in_window;
  logic        ack_ok, nak_ok, progress, outstanding_d, replay_event;
  logic [11:0] ack_dist, win;

  assign next_seq      = last_tx + 12'd1;
  assign replay_active = (state_q == REPLAY);

  // Window test uses pre-update last_tx/acked_seq, so a same-cycle tx_start
  // cannot widen the window for the ACK arriving with it.
  assign is_ack    = (ack_nack == 2'b01);
  assign is_nak    = (ack_nack == 2'b10);
  assign ack_dist  = ack_seq - acked_seq;
  assign win       = last_tx - acked_seq;
  assign in_window = (ack_dist <= win);

  // NAKs are dropped wholesale while a replay is already in progress.
  assign ack_ok    = is_ack && in_window;
  assign nak_ok    = is_nak && in_window && (state_q != REPLAY);
  assign ack_err_d = (is_ack || (is_nak && state_q != REPLAY)) && !in_window;
  assign progress  = (ack_ok || nak_ok) && (ack_seq != acked_seq);

  assign last_tx_d     = tx_start ? next_seq : last_tx;
  assign acked_seq_d   = (ack_ok || nak_ok) ? ack_seq : acked_seq;
  assign outstanding_d = (last_tx_d != acked_seq_d);

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    replay_event = 1'b0;
    tim_out_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = RUN;
          timer_d = 16'd0;
        end
      end
      RUN: begin
        if (nak_ok) begin
          replay_event = 1'b1;
          state_d      = REPLAY;
          timer_d      = 16'd0;
        end else if (progress) begin
          // Forward progress beats a coincident timeout.
          timer_d = 16'd0;
          if (!outstanding_d) state_d = IDLE;
        end else if (timer_q == TIMER_MAX) begin
          tim_out_d    = 1'b1;
          replay_event = 1'b1;
          state_d      = REPLAY;
          timer_d      = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      REPLAY: begin
        timer_d = 16'd0;
        if (replay_done) state_d = outstanding_d ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = 16'd0;
      end
    endcase
  end

  // Progress clears the count before a same-cycle replay event adds to it.
  always_comb begin
    rn_base      = progress ? 2'd0 : replay_num;
    replay_num_d = rn_base;
    rollover_d   = 1'b0;
    if (replay_event) begin
      if (rn_base == 2'd3) begin
        replay_num_d = 2'd0;
        rollover_d   = 1'b1;
      end else begin
        replay_num_d = rn_base + 2'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_tx    <= 12'hfff;
      acked_seq  <= 12'hfff;
      timer_q    <= 16'd0;
      replay_num <= 2'd0;
      tim_out    <= 1'b0;
      rollover   <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_tx    <= last_tx_d;
      acked_seq  <= acked_seq_d;
      timer_q    <= timer_d;
      replay_num <= replay_num_d;
      tim_out    <= tim_out_d;
      rollover   <= rollover_d;
      ack_err    <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_replay_timer.sv
// Scoreboard bench for replay_timer: stimulus queues expected status and
// pulses by cycle number, a negedge monitor pops and compares them.
module tb_replay_timer;

  localparam int T = 8;
  localparam int K_TIM  = 0;
  localparam int K_ROLL = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_start;
  logic [1:0]  ack_nack;
  logic [11:0] ack_seq;
  logic        replay_done;
  logic [11:0] next_seq;
  logic        tim_out;
  logic        replay_active;
  logic [1:0]  replay_num;
  logic        rollover;
  logic        ack_err;

  replay_timer #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .ack_nack     (ack_nack),
    .ack_seq      (ack_seq),
    .replay_done  (replay_done),
    .next_seq     (next_seq),
    .tim_out      (tim_out),
    .replay_active(replay_active),
    .replay_num   (replay_num),
    .rollover     (rollover),
    .ack_err      (ack_err)
  );

  always #5 clk = ~clk;

  // cyc == n at the negedge following rising edge n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    logic [11:0] ns;
    logic        ra;
    logic [1:0]  rn;
    string       tag;
  } status_t;

  typedef struct {
    int    cycle;
    int    kind;
    string tag;
  } pulse_t;

  status_t status_q[$];
  pulse_t  pulse_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic string kname(input int k);
    case (k)
      K_TIM:   return "tim_out";
      K_ROLL:  return "rollover";
      default: return "ack_err";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_status(input int c, input logic [11:0] ns, input logic ra,
                            input logic [1:0] rn, input string tag);
    status_t s;
    s.cycle = c; s.ns = ns; s.ra = ra; s.rn = rn; s.tag = tag;
    status_q.push_back(s);
  endtask

  task automatic exp_pulse(input int c, input int kind, input string tag);
    pulse_t p;
    p.cycle = c; p.kind = kind; p.tag = tag;
    pulse_q.push_back(p);
  endtask

  task automatic see_pulse(input int kind);
    int idx = -1;
    for (int i = 0; i < pulse_q.size(); i++) begin
      if (pulse_q[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s: pulse at cycle %0d, none expected", kname(kind), cyc);
    end else begin
      check({"pulse_", pulse_q[idx].tag}, cyc, pulse_q[idx].cycle);
      pulse_q.delete(idx);
    end
  endtask

  // Monitor: compare due status entries, account for every pulse seen.
  always @(negedge clk) begin
    status_t s;
    for (int i = pulse_q.size() - 1; i >= 0; i--) begin
      if (pulse_q[i].cycle < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_%s: %s expected at cycle %0d, absent", kname(pulse_q[i].kind),
                 pulse_q[i].tag, pulse_q[i].cycle);
        pulse_q.delete(i);
      end
    end
    while (status_q.size() > 0 && status_q[0].cycle <= cyc) begin
      s = status_q.pop_front();
      check({s.tag, ".next_seq"},      32'(next_seq),      32'(s.ns));
      check({s.tag, ".replay_active"}, 32'(replay_active), 32'(s.ra));
      check({s.tag, ".replay_num"},    32'(replay_num),    32'(s.rn));
    end
    if (tim_out)  see_pulse(K_TIM);
    if (rollover) see_pulse(K_ROLL);
    if (ack_err)  see_pulse(K_ERR);
  end

  task automatic drive(input logic tx, input logic [1:0] an, input logic [11:0] sq, input logic done);
    tx_start = tx; ack_nack = an; ack_seq = sq; replay_done = done;
    @(negedge clk);
    tx_start = 1'b0; ack_nack = 2'b00; ack_seq = 12'd0; replay_done = 1'b0;
  endtask

  // Advance so the next drive() lands on rising edge e.
  task automatic goto_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, ".rst_next_seq"},      32'(next_seq),      32'd0);
    check({tag, ".rst_replay_active"}, 32'(replay_active), 32'd0);
    check({tag, ".rst_replay_num"},    32'(replay_num),    32'd0);
    check({tag, ".rst_pulses"},        32'({tim_out, rollover, ack_err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, e;
    reset = 1'b1;
    tx_start = 1'b0; ack_nack = 2'b00; ack_seq = 12'd0; replay_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("init.next_seq",  32'(next_seq),      32'd0);
    check("init.last_tx",   32'(dut.last_tx),   32'd4095);
    check("init.acked_seq", 32'(dut.acked_seq), 32'd4095);
    check("init.timer",     32'(dut.timer_q),   32'd0);
    check("init.outputs",   32'({tim_out, replay_active, replay_num, rollover, ack_err}), 32'd0);
    reset = 1'b0;

    // Single TLP, no ACK: timeout 8 cycles later, then three more timeouts.
    t = cyc + 1;
    exp_status(t, 12'd1, 1'b0, 2'd0, "to.after_tx");
    exp_status(t + T - 1, 12'd1, 1'b0, 2'd0, "to.before_exp");
    exp_pulse(t + T, K_TIM, "to.tim1");
    exp_status(t + T, 12'd1, 1'b1, 2'd1, "to.rep1");
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    goto_edge(t + T + 3);
    for (int r = 2; r <= 4; r++) begin
      d = cyc + 1;
      exp_status(d, 12'd1, 1'b0, 2'(r - 1), "to.after_done");
      exp_pulse(d + T, K_TIM, "to.timN");
      if (r == 4) exp_pulse(d + T, K_ROLL, "to.rollover");
      exp_status(d + T, 12'd1, 1'b1, 2'(r % 4), "to.repN");
      drive(1'b0, 2'b00, 12'd0, 1'b1);
      goto_edge(d + T + 2);
    end
    do_reset("mid_replay");

    // Reset mid-RUN: no timeout may follow.
    t = cyc + 1;
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    goto_edge(t + 4);
    do_reset("mid_run");
    exp_status(cyc + 2 * T, 12'd0, 1'b0, 2'd0, "mid_run.quiet");
    goto_edge(cyc + 2 * T + 2);

    // Three TLPs then ACK 2 returns to IDLE without any timeout.
    t = cyc + 1;
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    exp_status(t + 3, 12'd3, 1'b0, 2'd0, "ack3.after_ack");
    exp_status(t + 3 + 2 * T, 12'd3, 1'b0, 2'd0, "ack3.quiet");
    drive(1'b0, 2'b01, 12'd2, 1'b0);
    goto_edge(t + 3 + 2 * T + 2);
    check("ack3.acked_seq", 32'(dut.acked_seq), 32'd2);
    do_reset("r3");

    // Out-of-window ACK, reserved code ignored, NAK ignored during REPLAY.
    t = cyc + 1;
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    drive(1'b0, 2'b11, 12'd7, 1'b0);
    exp_pulse(t + 3, K_ERR, "bad.ack_err");
    exp_pulse(t + T, K_TIM, "bad.tim");
    exp_status(t + T, 12'd2, 1'b1, 2'd1, "bad.rep");
    drive(1'b0, 2'b01, 12'd7, 1'b0);
    check("bad.acked_seq", 32'(dut.acked_seq), 32'd4095);
    goto_edge(t + T + 2);
    e = cyc + 1;
    exp_status(e, 12'd2, 1'b1, 2'd1, "bad.nak_ignored");
    drive(1'b0, 2'b10, 12'd0, 1'b0);
    exp_status(e + 1, 12'd2, 1'b1, 2'd0, "bad.ack_in_replay");
    drive(1'b0, 2'b01, 12'd1, 1'b0);
    exp_status(e + 2, 12'd2, 1'b0, 2'd0, "bad.done_idle");
    exp_status(e + 2 + 2 * T, 12'd2, 1'b0, 2'd0, "bad.quiet");
    drive(1'b0, 2'b00, 12'd0, 1'b1);
    goto_edge(e + 2 + 2 * T + 2);
    do_reset("r4");

    // NAK coincident with timeout, then a NAK mid-RUN.
    t = cyc + 1;
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    goto_edge(t + T);
    exp_status(t + T, 12'd1, 1'b1, 2'd1, "nak.coincident");
    drive(1'b0, 2'b10, 12'd4095, 1'b0);
    goto_edge(t + T + 3);
    d = cyc + 1;
    exp_status(d, 12'd1, 1'b0, 2'd1, "nak.resume");
    drive(1'b0, 2'b00, 12'd0, 1'b1);
    goto_edge(d + 3);
    exp_status(d + 3, 12'd1, 1'b1, 2'd2, "nak.midrun");
    drive(1'b0, 2'b10, 12'd4095, 1'b0);
    e = cyc + 1;
    exp_status(e, 12'd1, 1'b0, 2'd2, "nak.resume2");
    drive(1'b0, 2'b00, 12'd0, 1'b1);
    exp_status(e + 1, 12'd1, 1'b0, 2'd0, "nak.ack_idle");
    exp_status(e + 1 + 2 * T, 12'd1, 1'b0, 2'd0, "nak.quiet");
    drive(1'b0, 2'b01, 12'd0, 1'b0);
    goto_edge(e + 1 + 2 * T + 2);
    do_reset("r5");

    // Forward-progress ACK coincident with timeout restarts the timer.
    t = cyc + 1;
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    drive(1'b1, 2'b00, 12'd0, 1'b0);
    goto_edge(t + T);
    exp_status(t + T, 12'd2, 1'b0, 2'd0, "fp.ack_wins");
    exp_pulse(t + 2 * T, K_TIM, "fp.late_tim");
    exp_status(t + 2 * T, 12'd2, 1'b1, 2'd1, "fp.late_rep");
    drive(1'b0, 2'b01, 12'd0, 1'b0);
    goto_edge(t + 2 * T + 2);
    do_reset("r6");

    // Sequence wrap: TX with same-cycle ACK of the previous TLP every cycle.
    for (int i = 0; i < 4095; i++) begin
      if (i == 4094) exp_status(cyc + 1, 12'd4095, 1'b0, 2'd0, "wrap.ns4095");
      drive(1'b1, 2'b01, 12'(i - 1), 1'b0);
    end
    e = cyc + 1;
    exp_status(e, 12'd0, 1'b0, 2'd0, "wrap.ns0");
    drive(1'b1, 2'b01, 12'd4094, 1'b0);
    exp_status(e + 1, 12'd0, 1'b0, 2'd0, "wrap.ack_idle");
    exp_status(e + 1 + 2 * T, 12'd0, 1'b0, 2'd0, "wrap.quiet");
    drive(1'b0, 2'b01, 12'd4095, 1'b0);
    goto_edge(e + 1 + 2 * T + 2);
    check("wrap.acked_seq", 32'(dut.acked_seq), 32'd4095);

    repeat (3) @(negedge clk);
    foreach (pulse_q[i]) begin
      checks++;
      failures++;
      $display("FAIL leftover_%s: %s expected at cycle %0d", kname(pulse_q[i].kind),
               pulse_q[i].tag, pulse_q[i].cycle);
    end
    foreach (status_q[i]) begin
      checks++;
      failures++;
      $display("FAIL leftover_status: %s at cycle %0d never compared", status_q[i].tag,
               status_q[i].cycle);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
